// File: rtl/uart_frame_assembler_if.sv
// ---------------------------------------------------------------------------
// uart_frame_assembler_if
//   Groups the byte-stream handshake and the frame-result signals of the
//   UART frame assembler.
//   master : byte source / frame consumer (drives in_valid, in_data, flush)
//   slave  : the assembler itself
//   Signals:
//     in_valid, in_data, in_ready : received-byte handshake
//     flush                       : synchronous discard of the partial frame
//     frame_out                   : last good frame (byte k at [8k+7:8k])
//     frame_valid / frame_err     : one-cycle result pulses
//     err_timeout                 : qualifies frame_err (1 = inter-byte timeout)
//     byte_count                  : bytes currently held in the partial frame
// ---------------------------------------------------------------------------
interface uart_frame_assembler_if #(
  parameter int FRAME_BYTES = 18,
  parameter int DBITS       = 8
);
  localparam int CW = $clog2(FRAME_BYTES + 1);

  logic                         in_valid;
  logic [DBITS-1:0]             in_data;
  logic                         in_ready;
  logic                         flush;
  logic [FRAME_BYTES*DBITS-1:0] frame_out;
  logic                         frame_valid;
  logic                         frame_err;
  logic                         err_timeout;
  logic [CW-1:0]                byte_count;

  modport master (
    output in_valid, in_data, flush,
    input  in_ready, frame_out, frame_valid, frame_err, err_timeout, byte_count
  );

  modport slave (
    input  in_valid, in_data, flush,
    output in_ready, frame_out, frame_valid, frame_err, err_timeout, byte_count
  );
endinterface

// File: rtl/uart_frame_assembler.sv
// ---------------------------------------------------------------------------
// uart_frame_assembler
//   Collects FRAME_BYTES bytes from the UART RX stream into a shadow frame and
//   checks that the first byte (command char) equals the last byte (end char).
//   A good frame is copied to frame_out with a one-cycle frame_valid pulse; a
//   bad frame gives a one-cycle frame_err pulse and frame_out is left alone.
//   Optional feature macro: UART_FRAME_TIMEOUT_EN
//     defined   -> an inter-byte idle counter discards a stalled partial frame
//                  after TIMEOUT_CYCLES idle cycles (frame_err + err_timeout).
//     undefined -> no counter; a partial frame waits for flush or reset.
//   Ports:
//     clk_ext : system clock
//     nreset  : asynchronous active-low reset
//     bus     : uart_frame_assembler_if.slave (byte handshake + frame results)
// ---------------------------------------------------------------------------
module uart_frame_assembler #(
  parameter int FRAME_BYTES    = 18,
  parameter int DBITS          = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_BITS        = 24
) (
  input  logic                    clk_ext,
  input  logic                    nreset,
  uart_frame_assembler_if.slave   bus
);
  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam int FW = FRAME_BYTES * DBITS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

  logic [1:0]    state_r;
  logic [CW-1:0] count_r;
  logic [FW-1:0] shadow_r;
  logic [FW-1:0] frame_out_r;
  logic          frame_valid_r;
  logic          frame_err_r;
  logic          err_timeout_r;

  logic          in_ready_s;
  logic          accept_s;
  logic          last_byte_s;
  logic          delim_match_s;
  logic          timeout_hit_s;

  // Handshake and frame-check decode
  always_comb begin
    in_ready_s    = (state_r != ST_EMIT);
    accept_s      = bus.in_valid & in_ready_s;
    last_byte_s   = (count_r == CW'(FRAME_BYTES - 1));
    delim_match_s = (shadow_r[DBITS-1:0] == shadow_r[(FRAME_BYTES-1)*DBITS +: DBITS]);
  end

`ifdef UART_FRAME_TIMEOUT_EN
  logic [TO_BITS-1:0] to_cnt_r;

  // Idle-cycle counter: runs only while a partial frame is being collected
  always_ff @(posedge clk_ext or negedge nreset) begin
    if (!nreset) begin
      to_cnt_r <= {TO_BITS{1'b0}};
    end else if (bus.flush || (state_r != ST_COLLECT) || accept_s || timeout_hit_s) begin
      to_cnt_r <= {TO_BITS{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TO_BITS'(1);
    end
  end

  assign timeout_hit_s = (state_r == ST_COLLECT) && (to_cnt_r == TO_BITS'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout feature the sizing parameters only keep the
  // instantiation interface identical; the condition is constant zero.
  assign timeout_hit_s = 1'b0 & (TO_BITS > 0) & (TIMEOUT_CYCLES > 0);
`endif

  // Frame FSM, shadow capture and registered result pulses
  always_ff @(posedge clk_ext or negedge nreset) begin
    if (!nreset) begin
      state_r       <= ST_IDLE;
      count_r       <= {CW{1'b0}};
      shadow_r      <= {FW{1'b0}};
      frame_out_r   <= {FW{1'b0}};
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      err_timeout_r <= 1'b0;
      if (bus.flush) begin
        // Flush wins over a simultaneous byte and over a full frame in EMIT.
        state_r <= ST_IDLE;
        count_r <= {CW{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE, ST_COLLECT: begin
            if (accept_s) begin
              shadow_r[int'(count_r)*DBITS +: DBITS] <= bus.in_data;
              count_r <= count_r + CW'(1);
              state_r <= last_byte_s ? ST_EMIT : ST_COLLECT;
            end else if (timeout_hit_s) begin
              state_r       <= ST_IDLE;
              count_r       <= {CW{1'b0}};
              frame_err_r   <= 1'b1;
              err_timeout_r <= 1'b1;
            end else begin
              state_r <= state_r;
            end
          end
          ST_EMIT: begin
            if (delim_match_s) begin
              frame_out_r   <= shadow_r;
              frame_valid_r <= 1'b1;
            end else begin
              frame_err_r   <= 1'b1;
            end
            state_r <= ST_IDLE;
            count_r <= {CW{1'b0}};
          end
          default: begin
            state_r <= ST_IDLE;
            count_r <= {CW{1'b0}};
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.frame_out   = frame_out_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.err_timeout = err_timeout_r;
  assign bus.byte_count  = count_r;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_assembler
//   Directed scenarios plus randomized frames against a queue-based reference
//   model. The model predicts each result pulse and pushes it into a scoreboard
//   queue; an independent monitor pops it on every negative clock edge.
// ---------------------------------------------------------------------------
module tb_uart_frame_assembler;
  localparam int FB  = 18;
  localparam int DB  = 8;
  localparam int W   = FB * DB;
  localparam int TMO = 16;
  localparam int CW  = $clog2(FB + 1);

  typedef struct {
    bit           good;
    bit           tmo;
    logic [W-1:0] frame;
  } exp_t;

  logic clk_ext = 1'b0;
  logic nreset  = 1'b0;

  uart_frame_assembler_if #(.FRAME_BYTES(FB), .DBITS(DB)) bus ();

  uart_frame_assembler #(
    .FRAME_BYTES(FB), .DBITS(DB), .TIMEOUT_CYCLES(TMO), .TO_BITS(5)
  ) dut (
    .clk_ext (clk_ext),
    .nreset  (nreset),
    .bus     (bus.slave)
  );

  always #5 clk_ext = ~clk_ext;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   partial[$];
  bit           emit_pend  = 1'b0;
  logic [W-1:0] last_frame = '0;
  int           idle_cyc   = 0;
  bit           m_taken    = 1'b0;
  exp_t         expq[$];
  int           cyc        = 0;

  always @(posedge clk_ext or negedge nreset) begin
    if (!nreset) begin
      partial.delete();
      emit_pend  = 1'b0;
      last_frame = '0;
      idle_cyc   = 0;
      m_taken    = 1'b0;
      expq.delete();
    end else begin
      cyc++;
      m_taken = bus.in_valid && !emit_pend;
      if (bus.flush) begin
        partial.delete();
        emit_pend = 1'b0;
        idle_cyc  = 0;
      end else if (emit_pend) begin
        exp_t e;
        logic [W-1:0] f;
        f = '0;
        for (int i = 0; i < FB; i++) f[i*8 +: 8] = partial[i];
        e.good  = (partial[0] == partial[FB-1]);
        e.tmo   = 1'b0;
        e.frame = e.good ? f : last_frame;
        if (e.good) last_frame = f;
        expq.push_back(e);
        partial.delete();
        emit_pend = 1'b0;
      end else if (m_taken) begin
        partial.push_back(bus.in_data);
        idle_cyc = 0;
        if (partial.size() == FB) emit_pend = 1'b1;
      end else if (partial.size() > 0) begin
        idle_cyc++;
`ifdef UART_FRAME_TIMEOUT_EN
        if (idle_cyc == TMO) begin
          exp_t e;
          e.good  = 1'b0;
          e.tmo   = 1'b1;
          e.frame = last_frame;
          expq.push_back(e);
          partial.delete();
          idle_cyc = 0;
        end
`endif
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int vtimes[$];
  int n_valid = 0;

  always @(negedge clk_ext) begin
    chk("in_ready",   bus.in_ready,   !emit_pend);
    chk("byte_count", bus.byte_count, partial.size());
    chk("frame_out",  bus.frame_out,  last_frame);
    chk("pulse_excl", bus.frame_valid & bus.frame_err, 1'b0);
    if (bus.frame_valid || bus.frame_err) begin
      if (expq.size() == 0) begin
        chk("unexpected_pulse", {bus.frame_valid, bus.frame_err}, 2'b00);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("frame_valid", bus.frame_valid, e.good);
        chk("frame_err",   bus.frame_err,   !e.good);
        chk("err_timeout", bus.err_timeout, e.tmo);
      end
      if (bus.frame_valid) begin
        vtimes.push_back(cyc);
        n_valid++;
      end
    end else if (expq.size() > 0) begin
      void'(expq.pop_front());
      chk("missing_pulse", 1'b0, 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit with_flush);
    int tries;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.flush    = with_flush;
    tries = 0;
    forever begin
      @(posedge clk_ext);
      #1;
      if (m_taken) break;
      tries++;
      if (tries > 4) begin
        chk("accept_bound", 1'b0, 1'b1);
        break;
      end
    end
    bus.flush = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    repeat (n) @(posedge clk_ext);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] first, input logic [7:0] fill, input logic [7:0] last);
    send_byte(first, 1'b0);
    for (int i = 1; i < FB - 1; i++) send_byte(fill, 1'b0);
    send_byte(last, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.flush    = 1'b0;

    // Reset values
    #13;
    chk("rst_frame_out",  bus.frame_out,  '0);
    chk("rst_byte_count", bus.byte_count, 0);
    chk("rst_in_ready",   bus.in_ready,   1'b1);
    chk("rst_pulses",     {bus.frame_valid, bus.frame_err, bus.err_timeout}, 3'b000);
    #10 nreset = 1'b1;
    @(posedge clk_ext); #1;

    // 1: good frame "@A" + 15 x 0x00 + "@"
    send_byte(8'h40, 1'b0);
    send_byte(8'h41, 1'b0);
    for (int i = 0; i < 15; i++) send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    idle(3);
    chk("t1_b0",  bus.frame_out[7:0],     8'h40);
    chk("t1_b1",  bus.frame_out[15:8],    8'h41);
    chk("t1_b17", bus.frame_out[143:136], 8'h40);

    // 2: delimiter mismatch keeps the previous frame
    send_frame(8'h42, 8'h11, 8'h43);
    idle(3);
    chk("t2_held", bus.frame_out[15:8], 8'h41);
    chk("t2_cnt",  bus.byte_count,      0);

    // 3: two good frames back-to-back, pulses 19 cycles apart
    nv0 = n_valid;
    send_frame(8'h41, 8'h5A, 8'h41);
    send_frame(8'h44, 8'hA5, 8'h44);
    idle(3);
    chk("t3_npulse", n_valid - nv0, 2);
    if (vtimes.size() >= 2)
      chk("t3_spacing", vtimes[vtimes.size()-1] - vtimes[vtimes.size()-2], 19);

    // 4: flush together with the 6th byte, then a full frame
    nv0 = n_valid;
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1'b0);
    send_byte(8'h35, 1'b1);
    idle(1);
    chk("t4_cnt_flush", bus.byte_count, 0);
    send_frame(8'h40, 8'h77, 8'h40);
    idle(3);
    chk("t4_npulse", n_valid - nv0, 1);
    chk("t4_fill",   bus.frame_out[15:8], 8'h77);

    // 4b: flush in the EMIT cycle drops a full good frame silently
    nv0 = n_valid;
    send_frame(8'h55, 8'h66, 8'h55);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    @(posedge clk_ext); #1;
    bus.flush = 1'b0;
    idle(3);
    chk("t4b_npulse", n_valid - nv0, 0);

    // 5: stall after 3 bytes
    send_byte(8'h5A, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    idle(20);
`ifndef UART_FRAME_TIMEOUT_EN
    for (int i = 0; i < 14; i++) send_byte(8'h03, 1'b0);
    send_byte(8'h5A, 1'b0);
    idle(3);
    chk("t5_frame_end", bus.frame_out[143:136], 8'h5A);
`endif
    chk("t5_cnt", bus.byte_count, 0);

    // 6: async reset after 10 bytes
    for (int i = 0; i < 10; i++) send_byte(8'h20 + 8'(i), 1'b0);
    bus.in_valid = 1'b0;
    #2 nreset = 1'b0;
    #1;
    chk("t6_frame_out", bus.frame_out,  '0);
    chk("t6_cnt",       bus.byte_count, 0);
    chk("t6_ready",     bus.in_ready,   1'b1);
    #9 nreset = 1'b1;
    @(posedge clk_ext); #1;
    send_frame(8'h61, 8'h62, 8'h61);
    idle(3);
    chk("t6_b0", bus.frame_out[7:0], 8'h61);

    // Randomized frames with gaps and occasional flushes
    for (int f = 0; f < 40; f++) begin
      logic [7:0] first;
      logic [7:0] last;
      bit good;
      int fpos;
      first = 8'($urandom_range(0, 255));
      good  = ($urandom_range(0, 1) == 1);
      last  = good ? first : (first ^ 8'($urandom_range(1, 255)));
      fpos  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, FB - 1)) : FB + 1;
      for (int i = 0; i < FB; i++) begin
        if (i == fpos) begin
          bus.in_valid = 1'b0;
          bus.flush    = 1'b1;
          @(posedge clk_ext); #1;
          bus.flush = 1'b0;
          break;
        end
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if (i == 0)           send_byte(first, 1'b0);
        else if (i == FB - 1) send_byte(last, 1'b0);
        else                  send_byte(8'($urandom_range(0, 255)), 1'b0);
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(5);
    chk("end_queue_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
